roll_history: RTL
=================

// Module: roll_history
// PURPOSE
// - Consumer/reader end of the random-roll path: captures each settled 4-bit roll from the generator in a circular history.
// - Lets the player step back and forward through past rolls on a single display.
// - Sits between the LFSR roll generator and the seven-segment driver; o_view_data feeds the display.
// PARAMETERS
// - WIDTH  4  bits per roll value
// - DEPTH  8  history entries; power of two, >= 2
// PORTS
// - i_clk         in   1                 system clock; all state changes on posedge
// - i_rst         in   1                 synchronous, active-high reset
// - i_wr_valid    in   1                 generator presents a settled roll this cycle
// - i_wr_data     in   WIDTH             settled roll value
// - o_wr_ready    out  1                 history accepts a write this cycle
// - i_prev        in   1                 one-cycle pulse: step one entry older
// - i_next        in   1                 one-cycle pulse: step one entry newer
// - i_clear       in   1                 one-cycle pulse: wipe history
// - o_view_data   out  WIDTH             entry currently shown
// - o_view_idx    out  $clog2(DEPTH)     age of shown entry; 0 = newest
// - o_count       out  $clog2(DEPTH+1)   valid entries, saturates at DEPTH
// - o_viewing     out  1                 1 while in S_REPLAY
// BEHAVIOUR
// - Registers: state, wr_ptr, count, offset, clr_ptr.
// - Outputs are combinational from the registers and the async RAM read, so every effect is visible the cycle after the accepting edge.
// - Reset: state=S_LIVE, wr_ptr=0, count=0, offset=0.
//   - Reset output values: o_view_data=0, o_view_idx=0, o_count=0, o_viewing=0, o_wr_ready=1.
//   - RAM contents are not reset; they are unreadable while count=0.
//   - Reset mid-clear aborts the clear.
// - S_LIVE: o_wr_ready=1, offset=0.
//   - o_view_data = mem[wr_ptr-1], or 0 when count=0.
// - S_REPLAY: o_wr_ready=1, o_viewing=1.
//   - o_view_data = mem[wr_ptr-1-offset]; index arithmetic is mod DEPTH (wraps naturally in $clog2(DEPTH) bits).
// - S_CLEAR: o_wr_ready=0, o_view_data=0.
//   - Writes 0 to mem[clr_ptr] and increments clr_ptr each cycle, for exactly DEPTH cycles.
//   - Then goes to S_LIVE with wr_ptr=0, count=0, offset=0.
// - Accepted write (i_wr_valid & o_wr_ready):
//   - mem[wr_ptr] <= i_wr_data; wr_ptr++ (wraps DEPTH-1 -> 0); count = min(count+1, DEPTH).
//   - Once full, the oldest entry is overwritten.
// - Transitions; priority per cycle is clear > write > prev/next:
//   - any state, i_clear: -> S_CLEAR, clr_ptr=0. A simultaneous write is dropped; i_clear during S_CLEAR restarts the wipe.
//   - S_LIVE/S_REPLAY, accepted write: -> S_LIVE, offset=0. A new roll aborts replay; prev/next in the same cycle are ignored.
//   - S_LIVE, i_prev & count>=2: -> S_REPLAY, offset=1. With count<2, i_prev is ignored.
//   - S_REPLAY, i_prev: offset++ if offset < count-1, else hold (oldest entry is sticky).
//   - S_REPLAY, i_next: offset-- ; if offset was 1 -> S_LIVE, offset=0.
//   - S_LIVE, i_next: ignored.
//   - i_prev & i_next together: both ignored.
// - Pulse width: i_prev, i_next and i_clear are consumed every cycle they are high; the debouncer upstream guarantees one-cycle pulses.
// STRUCTURE
// - roll_history_pkg: state_t enum {S_LIVE, S_REPLAY, S_CLEAR}; default WIDTH and DEPTH localparams.
// - Sub-module history_ram: DEPTH x WIDTH register array; one synchronous write port, one asynchronous read port.
// - Top level: FSM, pointers and count. No other hierarchy.
// TESTING (DEPTH=8)
// - Reset, then write 3,9,5 on consecutive cycles -> o_count=3, o_view_data=5, o_view_idx=0, o_viewing=0.
// - From the previous case: i_prev x3 -> view 9 (idx1), then 3 (idx2), then 3 held (idx2);
//   then i_next x2 -> view 9, then 5 with o_viewing=0.
// - Write values 1..10 -> o_count=8, newest=10; i_prev x7 -> view 3 (idx7); one more i_prev -> still 3 (wrap and saturation).
// - In S_REPLAY at idx2, i_wr_valid=1 with data 12 plus i_prev in the same cycle -> next cycle S_LIVE, view 12, idx0.
// - i_clear together with i_wr_valid (data 7) -> write dropped, o_wr_ready=0 for exactly 8 cycles, then o_count=0, view 0.
// - Assert i_rst during cycle 4 of a clear -> next cycle S_LIVE, o_wr_ready=1, o_count=0; a write of 6 is then accepted and shown.

Source files
------------

// File: rtl/roll_history_pkg.sv
// Shared types and default sizing for the roll history block.
package roll_history_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    S_LIVE   = 2'd0,
    S_REPLAY = 2'd1,
    S_CLEAR  = 2'd2
  } state_t;

endpackage : roll_history_pkg

// File: rtl/history_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module history_ram #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read port.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule : history_ram

// File: rtl/roll_history.sv
// Circular history of settled rolls with step-back/step-forward replay and a timed wipe.
module roll_history
  import roll_history_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_prev,
  input  logic             i_next,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_view_data,
  output logic [AW-1:0]    o_view_idx,
  output logic [CW-1:0]    o_count,
  output logic             o_viewing
);

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] CLR_LAST   = AW'(DEPTH - 1);

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_offset;
  logic [AW-1:0]   r_clr_ptr;

  logic             w_in_clear;
  logic             w_wr_accept;
  logic             w_step_prev;
  logic             w_step_next;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_waddr;
  logic [WIDTH-1:0] w_ram_wdata;
  logic [AW-1:0]    w_ram_raddr;
  logic [WIDTH-1:0] w_ram_rdata;

  // Per-cycle qualifiers: clear beats write, write beats navigation, prev+next cancel.
  always_comb begin
    w_in_clear  = (r_state == S_CLEAR);
    w_wr_accept = i_wr_valid & ~w_in_clear & ~i_clear;
    w_step_prev = i_prev & ~i_next;
    w_step_next = i_next & ~i_prev;
  end

  // RAM port steering: the wipe owns the write port while clearing.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_wr_ptr;
    w_ram_wdata = i_wr_data;
    if (i_rst) begin
      w_ram_we = 1'b0;
    end else if (w_in_clear) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_clr_ptr;
      w_ram_wdata = '0;
    end else begin
      w_ram_we = w_wr_accept;
    end
    w_ram_raddr = r_wr_ptr - AW'(1) - r_offset;
  end

  history_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  // FSM, pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_LIVE;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_offset  <= '0;
      r_clr_ptr <= '0;
    end else if (i_clear) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_offset  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + AW'(1);
          if (r_clr_ptr == CLR_LAST) begin
            r_state  <= S_LIVE;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_offset <= '0;
          end
        end
        S_LIVE, S_REPLAY: begin
          if (w_wr_accept) begin
            r_state  <= S_LIVE;
            r_offset <= '0;
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_count != COUNT_FULL) begin
              r_count <= r_count + CW'(1);
            end
          end else if (w_step_prev) begin
            if (r_state == S_LIVE) begin
              if (r_count >= CW'(2)) begin
                r_state  <= S_REPLAY;
                r_offset <= AW'(1);
              end
            end else if (CW'(r_offset) < (r_count - CW'(1))) begin
              r_offset <= r_offset + AW'(1);
            end
          end else if (w_step_next && (r_state == S_REPLAY)) begin
            if (r_offset == AW'(1)) begin
              r_state  <= S_LIVE;
              r_offset <= '0;
            end else begin
              r_offset <= r_offset - AW'(1);
            end
          end
        end
        default: begin
          r_state <= S_LIVE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state and the asynchronous read.
  always_comb begin
    o_wr_ready  = ~w_in_clear;
    o_viewing   = (r_state == S_REPLAY);
    o_view_idx  = r_offset;
    o_count     = r_count;
    o_view_data = '0;
    if (!w_in_clear && (r_count != '0)) begin
      o_view_data = w_ram_rdata;
    end
  end

endmodule : roll_history
